// File: rtl/data_ram_if.sv
// Load/store bus between a core and data_ram.
// The master drives addresses and store data. The slave returns registered load data.
interface data_ram_if;
    logic [31:0] read_addr;
    logic [31:0] read_data;
    logic [1:0]  write_mode;
    logic [31:0] write_addr;
    logic [31:0] write_data;

    modport master (
        output read_addr,
        output write_mode,
        output write_addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  read_addr,
        input  write_mode,
        input  write_addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/data_ram.sv
// Byte-banked data RAM. Reads and writes may be unaligned and wrap at the top of memory.
// Reads are free-running with one cycle of latency. Writes of 1, 2 or 4 bytes commit on the clock edge.
module data_ram #(
    parameter int DEPTH     = 4096,
    parameter int ADDR_BITS = 14
) (
    input  logic     clk,
    input  logic     rst,
    data_ram_if.slave bus
);
    localparam int ROW_BITS = ADDR_BITS - 2;

    logic [1:0]          rd_off;
    logic [ROW_BITS-1:0] rd_row;
    logic [1:0]          wr_off;
    logic [ROW_BITS-1:0] wr_row;

    logic [ROW_BITS-1:0] rd_row_b [4];
    logic [ROW_BITS-1:0] wr_row_b [4];
    logic [1:0]          wr_k     [4];
    logic [7:0]          wr_byte  [4];
    logic [3:0]          wr_en;

    logic [31:0] rd_word;
    logic [63:0] rd_dbl;
    logic [1:0]  rd_off_q;
    logic        valid_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.read_addr[31:ADDR_BITS], bus.write_addr[31:ADDR_BITS]};

    assign rd_off = bus.read_addr[1:0];
    assign rd_row = bus.read_addr[ADDR_BITS-1:2];
    assign wr_off = bus.write_addr[1:0];
    assign wr_row = bus.write_addr[ADDR_BITS-1:2];

    // A bank below the start offset holds a byte from the following row.
    // The row index wraps at the top of memory.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            rd_row_b[b] = (2'(b) >= rd_off) ? rd_row : rd_row + 1'b1;
            wr_row_b[b] = (2'(b) >= wr_off) ? wr_row : wr_row + 1'b1;
            wr_k[b]     = 2'(b) - wr_off;
            wr_byte[b]  = bus.write_data[{wr_k[b], 3'b000} +: 8];
            case (bus.write_mode)
                2'b01:   wr_en[b] = rst && (wr_k[b] == 2'd0);
                2'b10:   wr_en[b] = rst && (wr_k[b] <= 2'd1);
                2'b11:   wr_en[b] = rst;
                default: wr_en[b] = 1'b0;
            endcase
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] mem [DEPTH];
        logic [7:0] q;

        // Read and write are in the same block, so a read on the write edge returns the old data.
        always_ff @(posedge clk) begin
            if (wr_en[b]) begin
                mem[wr_row_b[b]] <= wr_byte[b];
            end
            q <= mem[rd_row_b[b]];
        end

        assign rd_word[8*b +: 8] = q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            rd_off_q <= 2'b00;
        end else begin
            valid_q  <= 1'b1;
            rd_off_q <= rd_off;
        end
    end

    // Rotate the bank outputs so that byte 0 comes from the bank at the sampled offset.
    assign rd_dbl        = {rd_word, rd_word};
    assign bus.read_data = valid_q ? rd_dbl[{rd_off_q, 3'b000} +: 32] : 32'h0000_0000;
endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram. It checks directed and random stimulus against a flat byte-array model.
module tb_data_ram;
    localparam int DEPTH     = 4096;
    localparam int MEM_BYTES = DEPTH * 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] obs;

    data_ram_if bus ();

    data_ram #(.DEPTH(DEPTH), .ADDR_BITS(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = ref_mem[(a + 32'(k)) & 32'(MEM_BYTES - 1)];
        end
        return r;
    endfunction

    function automatic void model_write(input logic [1:0] wm, input logic [31:0] wa, input logic [31:0] wd);
        int n;
        n = (wm == 2'b11) ? 4 : int'(wm);
        for (int k = 0; k < n; k++) begin
            ref_mem[(wa + 32'(k)) & 32'(MEM_BYTES - 1)] = wd[8*k +: 8];
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Present one cycle of bus activity. The expected read is taken from the model before the write lands.
    task automatic step(input logic [31:0] ra, input logic [1:0] wm, input logic [31:0] wa,
                        input logic [31:0] wd, input bit chk, input string tag,
                        output logic [31:0] o);
        logic [31:0] e;
        bus.read_addr  = ra;
        bus.write_mode = wm;
        bus.write_addr = wa;
        bus.write_data = wd;
        @(posedge clk);
        e = model_read(ra);
        model_write(wm, wa, wd);
        #1;
        o = bus.read_data;
        if (chk) check(tag, o, e);
    endtask

    function automatic logic [31:0] pick_addr(input logic [31:0] other);
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h0000_3FF0 + 32'($urandom_range(0, 31));
            2:       return 32'h0000_0100 + 32'($urandom_range(0, 15));
            default: return other;
        endcase
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] wa;
        checks   = 0;
        failures = 0;
        rst            = 1'b0;
        bus.read_addr  = 32'h0;
        bus.write_mode = 2'b00;
        bus.write_addr = 32'h0;
        bus.write_data = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_read_data", bus.read_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Fill all of memory so that every later read has a defined expectation.
        for (int i = 0; i < DEPTH; i++) begin
            step(32'h0, 2'b11, 32'(i * 4), $urandom, 1'b0, "init", obs);
        end

        step(32'h0,   2'b11, 32'h100, 32'hDDCC_BBAA, 1'b1, "w_word_100", obs);
        step(32'h100, 2'b00, 32'h0,   32'h0,         1'b1, "r_100", obs);
        check("word_100_const", obs, 32'hDDCC_BBAA);

        step(32'h0,   2'b01, 32'h102, 32'h0000_0011, 1'b1, "w_byte_102", obs);
        step(32'h100, 2'b00, 32'h0,   32'h0,         1'b1, "r_100_b", obs);
        check("byte_merge_const", obs, 32'hDD11_BBAA);
        step(32'h101, 2'b00, 32'h0,   32'h0,         1'b1, "r_101", obs);
        check("unaligned_101_const", {8'h0, obs[23:0]}, 32'h00DD_11BB);

        step(32'h0,   2'b11, 32'h103, 32'h4433_2211, 1'b1, "w_word_103", obs);
        step(32'h100, 2'b00, 32'h0,   32'h0,         1'b1, "r_100_c", obs);
        check("cross_row_lo_const", obs, 32'h1111_BBAA);
        step(32'h104, 2'b00, 32'h0,   32'h0,         1'b1, "r_104", obs);
        check("cross_row_hi_const", {8'h0, obs[23:0]}, 32'h0044_3322);

        step(32'h0,    2'b10, 32'h3FFF, 32'h0000_BEEF, 1'b1, "w_half_top", obs);
        step(32'h3FFF, 2'b00, 32'h0,    32'h0,         1'b1, "r_3fff", obs);
        check("top_wrap_half_const", {16'h0, obs[15:0]}, 32'h0000_BEEF);
        step(32'h4000, 2'b00, 32'h0,    32'h0,         1'b1, "r_4000_alias", obs);
        check("alias_4000_byte0", {24'h0, obs[7:0]}, 32'h0000_00BE);
        step(32'hFFFF_0000, 2'b00, 32'h0, 32'h0,       1'b1, "r_high_bits_ignored", obs);

        step(32'h0,   2'b11, 32'h200, 32'hCAFE_F00D, 1'b1, "w_200", obs);
        step(32'h200, 2'b11, 32'h200, 32'h1234_5678, 1'b1, "rw_same_edge", obs);
        check("read_first_const", obs, 32'hCAFE_F00D);
        step(32'h200, 2'b00, 32'h200, 32'hFFFF_FFFF, 1'b1, "r_after_write", obs);
        check("write_visible_const", obs, 32'h1234_5678);
        step(32'h200, 2'b00, 32'h0,   32'h0,         1'b1, "mode0_no_write", obs);
        check("mode0_const", obs, 32'h1234_5678);

        for (int i = 0; i < 600; i++) begin
            wa = pick_addr(32'h100);
            ra = pick_addr(wa);
            step(ra, 2'($urandom_range(0, 3)), wa, $urandom, 1'b1, "rand", obs);
        end

        // Assert reset mid-cycle while a read is pending and a word write is presented.
        step(32'h0, 2'b11, 32'h300, 32'hA5A5_5A5A, 1'b1, "w_300", obs);
        bus.read_addr  = 32'h300;
        bus.write_mode = 2'b11;
        bus.write_addr = 32'h300;
        bus.write_data = 32'hDEAD_BEEF;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_read_data", bus.read_data, 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold_read_data", bus.read_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(32'h300, 2'b00, 32'h0, 32'h0, 1'b1, "r_after_reset", obs);
        check("reset_write_ignored_const", obs, 32'hA5A5_5A5A);

        for (int i = 0; i < 200; i++) begin
            wa = pick_addr(32'h3FFE);
            ra = pick_addr(wa);
            step(ra, 2'($urandom_range(0, 3)), wa, $urandom, 1'b1, "rand2", obs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
